// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock-divider controller.
//   clk_div_state_e : controller FSM states (idle, counting, update pending)
//   DIV_ONE         : smallest legal divide ratio
//   eff_div()       : maps a requested ratio of 0 onto 1
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } clk_div_state_e;

    localparam int unsigned DIV_ONE = 1;

    function automatic int unsigned eff_div(input int unsigned n);
        return (n == 0) ? DIV_ONE : n;
    endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Configuration handshake bundle for clk_div_ctrl.
//   cfg_div_i   : requested divide ratio (0 means 1), stable while valid
//   cfg_valid_i : request, held until cfg_ack_o
//   cfg_ack_o   : one-cycle pulse once the new ratio is active
//   busy_o      : an accepted request is waiting for the period boundary
// master = requester (control register / FLL block), slave = divider.
interface clk_div_ctrl_if #(
    parameter int DIV_W = 8
);
    logic [DIV_W-1:0] cfg_div_i;
    logic             cfg_valid_i;
    logic             cfg_ack_o;
    logic             busy_o;

    modport master (output cfg_div_i, cfg_valid_i, input cfg_ack_o, busy_o);
    modport slave  (input cfg_div_i, cfg_valid_i, output cfg_ack_o, busy_o);
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable clock-divider controller. Emits a one-cycle tick and a
// divided-clock phase level every div_q cycles of clk_i, for use as an ICG
// enable. Ratio changes requested while counting are deferred to the end of
// the current period so no period is ever truncated.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : run enable (low = idle, outputs low)
//   cfg           : configuration handshake (slave side)
//   tick_o        : registered, high for the first cycle of each period
//   phase_o       : registered, high for the first ceil(div/2) cycles
//   cur_div_o     : currently active ratio
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int          DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    clk_div_ctrl_if.slave    cfg,
    output logic             tick_o,
    output logic             phase_o,
    output logic [DIV_W-1:0] cur_div_o
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(eff_div(DEFAULT_DIV));
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    clk_div_state_e   state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             ack_q, busy_q, tick_q, phase_q;
    logic             blk_q;
    logic             apply, req, wrap, run_d;
    logic [DIV_W-1:0] req_div;
    logic [DIV_W:0]   half_d;

    // A request still held high in its own ack cycle is the old one; blk_q
    // masks cfg_valid_i until the requester has dropped it for a cycle.
    assign req     = cfg.cfg_valid_i & ~blk_q;
    assign req_div = DIV_W'(eff_div(32'(cfg.cfg_div_i)));
    assign wrap    = (cnt_q == div_q - ONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        pend_d  = pend_q;
        apply   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Config wins over a simultaneous enable: RUN starts with
                // the new ratio already loaded.
                if (req) begin
                    div_d = req_div;
                    apply = 1'b1;
                end
                if (en_i) state_d = RUN;
            end
            RUN: begin
                if (!en_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = wrap ? '0 : cnt_q + ONE;
                    if (req) begin
                        pend_d  = req_div;
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                // Switch only on a period boundary, or at once on disable
                // since the output is being gated anyway.
                if (!en_i || wrap) begin
                    div_d   = pend_q;
                    apply   = 1'b1;
                    cnt_d   = '0;
                    state_d = en_i ? RUN : IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values so the flop output lines
    // up with the cycle in which cnt holds the decoded value.
    assign run_d  = (state_d != IDLE);
    assign half_d = ({1'b0, div_d} + (DIV_W+1)'(1)) >> 1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= RST_DIV;
            pend_q  <= RST_DIV;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            phase_q <= 1'b0;
            blk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            ack_q   <= apply;
            busy_q  <= (state_d == PEND);
            tick_q  <= run_d && (cnt_d == '0);
            phase_q <= run_d && ({1'b0, cnt_d} < half_d);
            blk_q   <= apply | (blk_q & cfg.cfg_valid_i);
        end
    end

    assign tick_o        = tick_q;
    assign phase_o       = phase_q;
    assign cur_div_o     = div_q;
    assign cfg.cfg_ack_o = ack_q;
    assign cfg.busy_o    = busy_q;

endmodule
